// File: rtl/seq_detect_bcd_counter_if.sv
// Serial-bit in / detection-count out bundle for seq_detect_bcd_counter.
// The bit source (master) drives bit_in/bit_valid/clear; the detector (slave) drives the results.
interface seq_detect_bcd_counter_if #(
    parameter int DIGITS = 4
);
    logic                  bit_in;
    logic                  bit_valid;
    logic                  clear;
    logic                  match;
    logic [4*DIGITS-1:0]   count;
    logic                  max_tick;
    logic                  overflow;

    modport master (
        output bit_in, bit_valid, clear,
        input  match, count, max_tick, overflow
    );

    modport slave (
        input  bit_in, bit_valid, clear,
        output match, count, max_tick, overflow
    );
endinterface

// File: rtl/seq_detect_bcd_counter.sv
// Serial pattern detector with a BCD detection counter; bit_in is sampled only when bit_valid=1.
// All outputs are registered; reset and clear both return every register to zero.
module seq_detect_bcd_counter #(
    parameter int                 PAT_LEN  = 4,
    parameter logic [PAT_LEN-1:0] PATTERN  = 4'b1011,
    parameter bit                 OVERLAP  = 1'b1,
    parameter int                 DIGITS   = 4,
    parameter bit                 SATURATE = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    seq_detect_bcd_counter_if.slave sd
);
    localparam int FW = $clog2(PAT_LEN + 1);
    localparam int CW = 4 * DIGITS;

    function automatic logic [CW-1:0] f_all_nines();
        logic [CW-1:0] v;
        v = '0;
        for (int d = 0; d < DIGITS; d++) begin
            v[4*d +: 4] = 4'd9;
        end
        return v;
    endfunction

    localparam logic [CW-1:0] ALL9 = f_all_nines();

    logic [PAT_LEN-1:0] r_hist;
    logic [FW-1:0]      r_fill;
    logic               r_match;
    logic [CW-1:0]      r_count;
    logic               r_max_tick;
    logic               r_overflow;

    logic [PAT_LEN-1:0] w_hist_next;
    logic [FW-1:0]      w_fill_next;
    logic               w_hit;
    logic [CW-1:0]      w_count_inc;
    logic               w_at_all9;
    logic               w_reach_all9;
    logic               w_tick;

    assign w_hist_next = {r_hist[PAT_LEN-2:0], sd.bit_in};
    // Fill saturates at PAT_LEN so that reset zeros in the history are never mistaken for pattern bits.
    assign w_fill_next = (r_fill == FW'(PAT_LEN)) ? r_fill : r_fill + FW'(1);
    assign w_hit       = (w_hist_next == PATTERN) && (w_fill_next == FW'(PAT_LEN));

    // Ripple BCD increment: a 9 rolls to 0 and passes the carry upward.
    always_comb begin : p_bcd_inc
        logic v_carry;
        v_carry     = 1'b1;
        w_count_inc = r_count;
        for (int d = 0; d < DIGITS; d++) begin
            if (v_carry) begin
                if (r_count[4*d +: 4] == 4'd9) begin
                    w_count_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
                    v_carry               = 1'b0;
                end
            end
        end
    end

    assign w_at_all9    = (r_count == ALL9);
    assign w_reach_all9 = (w_count_inc == ALL9);
    // Wrap mode ticks on the roll-over; saturate mode ticks on the increment that lands on all-9s.
    assign w_tick       = SATURATE ? w_reach_all9 : w_at_all9;

    always_ff @(posedge clk) begin
        if (reset || sd.clear) begin
            r_hist     <= '0;
            r_fill     <= '0;
            r_match    <= 1'b0;
            r_count    <= '0;
            r_max_tick <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_match    <= 1'b0;
            r_max_tick <= 1'b0;
            if (sd.bit_valid) begin
                r_hist <= w_hist_next;
                if (w_hit) begin
                    r_match <= 1'b1;
                    r_fill  <= OVERLAP ? w_fill_next : '0;
                    if (!(SATURATE && w_at_all9)) begin
                        r_count <= w_count_inc;
                    end
                    if (w_tick) begin
                        r_max_tick <= 1'b1;
                        r_overflow <= 1'b1;
                    end
                end else begin
                    r_fill <= w_fill_next;
                end
            end
        end
    end

    assign sd.match    = r_match;
    assign sd.count    = r_count;
    assign sd.max_tick = r_max_tick;
    assign sd.overflow = r_overflow;

endmodule
